// File: rtl/traffic_light_fsm.sv
// Traffic light controller: GREEN -> YELLOW -> RED cycle paced by an external
// down-counter (init/en/last handshake), maintenance flashing-yellow mode and
// a latched pedestrian request served with a walk lamp during RED.
module traffic_light_fsm #(
   parameter int unsigned pINIT_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   last,
   input  logic                   flash_mode,
   input  logic                   ped_req,
   output logic [pINIT_WIDTH-1:0] init,
   output logic                   en,
   output logic                   light_g,
   output logic                   light_y,
   output logic                   light_r,
   output logic                   walk,
   output logic                   ped_ack,
   output logic [1:0]             state_out
);

   localparam logic [1:0] GREEN  = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] RED    = 2'd2;
   localparam logic [1:0] FLASH  = 2'd3;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic                   load;          // first cycle in GREEN/YELLOW/RED
   logic                   load_nxt;
   logic                   phase;         // flashing-yellow lamp phase
   logic                   phase_nxt;
   logic                   ped_pending;
   logic                   ped_pending_nxt;
   logic                   entering_red;
   logic                   walk_nxt;
   logic                   ped_ack_nxt;
   logic [pINIT_WIDTH-1:0] init_nxt;
   logic                   light_g_nxt;
   logic                   light_y_nxt;
   logic                   light_r_nxt;

   // Next state: flash request wins, leaving flash always lands in RED, and
   // the normal cycle only advances on an expired tick outside a load cycle.
   always_comb begin
      state_nxt = state;
      load_nxt  = 1'b0;
      phase_nxt = 1'b0;
      if (flash_mode) begin
         state_nxt = FLASH;
         phase_nxt = (state == FLASH) ? (phase ^ tick) : 1'b0;
      end else if (state == FLASH) begin
         state_nxt = RED;
         load_nxt  = 1'b1;
      end else if (tick && last && !load) begin
         load_nxt = 1'b1;
         case (state)
            GREEN:   state_nxt = YELLOW;
            YELLOW:  state_nxt = RED;
            default: state_nxt = GREEN;
         endcase
      end
   end

   // Pedestrian bookkeeping: a request is served at the next RED entry, and a
   // request arriving in the acknowledge cycle stays pending for the RED after.
   always_comb begin
      entering_red    = load_nxt && (state_nxt == RED);
      ped_pending_nxt = ped_req | (ped_pending & ~ped_ack);
      ped_ack_nxt     = entering_red & ped_pending;
      walk_nxt        = (state_nxt == RED) && (entering_red ? ped_pending : walk);
   end

   // One-hot counter load command, present only in the load cycle.
   always_comb begin
      init_nxt = '0;
      if (load_nxt) begin
         case (state_nxt)
            GREEN:   init_nxt[0] = 1'b1;
            YELLOW:  init_nxt[1] = 1'b1;
            RED:     init_nxt[2] = 1'b1;
            default: init_nxt    = '0;
         endcase
      end
   end

   // Lamp decode from the upcoming state so the lamps can be registered.
   always_comb begin
      light_g_nxt = (state_nxt == GREEN);
      light_y_nxt = (state_nxt == YELLOW) || ((state_nxt == FLASH) && phase_nxt);
      light_r_nxt = (state_nxt == RED);
   end

   // State and registered outputs; reset forces a GREEN load cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= GREEN;
         load        <= 1'b1;
         phase       <= 1'b0;
         ped_pending <= 1'b0;
         init        <= '0;
         init[0]     <= 1'b1;
         light_g     <= 1'b1;
         light_y     <= 1'b0;
         light_r     <= 1'b0;
         walk        <= 1'b0;
         ped_ack     <= 1'b0;
      end else begin
         state       <= state_nxt;
         load        <= load_nxt;
         phase       <= phase_nxt;
         ped_pending <= ped_pending_nxt;
         init        <= init_nxt;
         light_g     <= light_g_nxt;
         light_y     <= light_y_nxt;
         light_r     <= light_r_nxt;
         walk        <= walk_nxt;
         ped_ack     <= ped_ack_nxt;
      end
   end

   // Decrement enable: only on ticks, never while loading or flashing.
   always_comb begin
      en = tick && (init == '0) && (state != FLASH);
   end

   assign state_out = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: vector table, hand-written timing sequences
// with an attached light-counter model, and a randomized run against a
// behavioural model based on time-in-state.
module tb_traffic_light_fsm;

   logic       clk = 1'b0;
   logic       rst, tick, last, flash_mode, ped_req;
   logic [2:0] init;
   logic       en, light_g, light_y, light_r, walk, ped_ack;
   logic [1:0] state_out;

   logic       last_drv;
   logic       use_ctr;
   int         cnt;

   int         n_cmp = 0;
   int         n_bad = 0;

   // Behavioural model: current light, cycles spent in it, flash lamp,
   // pending request, and whether the current RED serves a request.
   int         m_light, m_age;
   bit         m_lit, m_pend, m_walk;

   typedef struct {
      logic        r, t, l, f, p;
      logic [10:0] exp;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   assign last = use_ctr ? (cnt == 0) : last_drv;

   traffic_light_fsm #(.pINIT_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .tick(tick), .last(last),
      .flash_mode(flash_mode), .ped_req(ped_req),
      .init(init), .en(en), .light_g(light_g), .light_y(light_y),
      .light_r(light_r), .walk(walk), .ped_ack(ped_ack), .state_out(state_out)
   );

   // Downstream light counter: G=14, Y=2, R=17.
   always @(posedge clk) begin
      if (init == 3'b001)      cnt <= 14;
      else if (init == 3'b010) cnt <= 2;
      else if (init == 3'b100) cnt <= 17;
      else if (en && cnt > 0)  cnt <= cnt - 1;
   end

   function automatic logic [10:0] outs();
      return {state_out, init, en, light_g, light_y, light_r, walk, ped_ack};
   endfunction

   function automatic logic [10:0] pk(input int st, input logic [2:0] i,
                                      input logic e, g, y, r, w, a);
      return {2'(st), i, e, g, y, r, w, a};
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, t, l, f, p);
      rst = r; tick = t; last_drv = l; flash_mode = f; ped_req = p;
   endtask

   task automatic do_reset(input logic ctr);
      use_ctr = ctr;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      m_light = 0; m_age = 0; m_lit = 0; m_pend = 0; m_walk = 0;
   endtask

   task automatic apply(input string name, input logic r, t, l, f, p, input logic [10:0] exp);
      drive(r, t, l, f, p);
      @(negedge clk);
      check(name, outs(), exp);
      @(posedge clk); #1;
   endtask

   task automatic add(input logic r, t, l, f, p, input int st, input logic [2:0] i,
                      input logic e, g, y, rr, w, a);
      vec_t v;
      v.r = r; v.t = t; v.l = l; v.f = f; v.p = p;
      v.exp = pk(st, i, e, g, y, rr, w, a);
      tbl.push_back(v);
   endtask

   function automatic logic [10:0] model_exp(input logic t);
      bit         first;
      logic [2:0] ei;
      first = (m_light != 3) && (m_age == 0);
      ei    = first ? 3'(1 << m_light) : 3'b000;
      return pk(m_light, ei, t && !first && (m_light != 3),
                m_light == 0, (m_light == 1) || (m_light == 3 && m_lit), m_light == 2,
                (m_light == 2) && m_walk, (m_light == 2) && first && m_walk);
   endfunction

   task automatic model_step(input logic r, t, l, f, p);
      bit first, ack_now, pend_old;
      first    = (m_light != 3) && (m_age == 0);
      ack_now  = (m_light == 2) && first && m_walk;
      pend_old = m_pend;
      if (r) begin
         m_light = 0; m_age = 0; m_lit = 0; m_pend = 0; m_walk = 0;
         return;
      end
      m_pend = p || (pend_old && !ack_now);
      if (f) begin
         if (m_light == 3) begin
            m_age++;
            if (t) m_lit = !m_lit;
         end else begin
            m_light = 3; m_age = 0; m_lit = 0;
         end
      end else if (m_light == 3) begin
         m_light = 2; m_age = 0; m_lit = 0; m_walk = pend_old;
      end else if (t && l && !first) begin
         m_light = (m_light + 1) % 3;
         m_age   = 0;
         if (m_light == 2) m_walk = pend_old;
      end else begin
         m_age++;
      end
   endtask

   initial begin
      logic [2:0] ei;
      logic       ew, ea, t, ok, saw_red, prev_t, fl;
      logic [1:0] prev_st;

      // ---------------- vector table ----------------
      //   r t l f p   st init  en g y r w a
      add(1,1,1,0,0,  0,3'b001,0,1,0,0,0,0);
      add(0,1,1,0,0,  0,3'b001,0,1,0,0,0,0);
      add(0,0,1,0,0,  0,3'b000,0,1,0,0,0,0);
      add(0,1,0,0,1,  0,3'b000,1,1,0,0,0,0);
      add(0,1,1,0,0,  0,3'b000,1,1,0,0,0,0);
      add(0,1,1,0,0,  1,3'b010,0,0,1,0,0,0);
      add(0,1,1,0,0,  1,3'b000,1,0,1,0,0,0);
      add(0,0,0,0,0,  2,3'b100,0,0,0,1,1,1);
      add(0,1,0,0,0,  2,3'b000,1,0,0,1,1,0);
      add(0,1,1,1,0,  2,3'b000,1,0,0,1,1,0);
      add(0,1,0,1,0,  3,3'b000,0,0,0,0,0,0);
      add(0,0,0,1,0,  3,3'b000,0,0,1,0,0,0);
      add(0,1,0,1,0,  3,3'b000,0,0,1,0,0,0);
      add(0,0,0,0,0,  3,3'b000,0,0,0,0,0,0);
      add(0,0,0,0,0,  2,3'b100,0,0,0,1,0,0);
      add(0,1,1,0,0,  2,3'b000,1,0,0,1,0,0);
      add(1,1,0,0,0,  0,3'b001,0,1,0,0,0,0);
      add(0,1,1,0,0,  0,3'b001,0,1,0,0,0,0);

      do_reset(1'b0);
      foreach (tbl[i])
         apply($sformatf("table_%0d", i), tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].f, tbl[i].p, tbl[i].exp);

      // ---------------- full-rate timing with counter, pedestrian ----------------
      do_reset(1'b1);
      for (int k = 0; k < 80; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, (k == 3) || (k == 20));
         ei = 3'b000;
         if (k == 0 || k == 39 || k == 78) ei = 3'b001;
         if (k == 16 || k == 55)           ei = 3'b010;
         if (k == 20 || k == 59)           ei = 3'b100;
         ew = (k >= 20 && k <= 38) || (k >= 59 && k <= 77);
         ea = (k == 20) || (k == 59);
         @(negedge clk);
         check($sformatf("timing_c%0d", k), 11'({init, walk, ped_ack}), 11'({ei, ew, ea}));
         @(posedge clk); #1;
      end

      // ---------------- tick every 4th cycle ----------------
      do_reset(1'b1);
      prev_st = 2'd0; prev_t = 1'b1; saw_red = 1'b0;
      for (int k = 0; k < 240; k++) begin
         t = (k % 4 == 0);
         drive(1'b0, t, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         ok = (!en || tick) && !(en && init != 3'b000) && (prev_t || state_out == prev_st);
         check($sformatf("tick4_c%0d", k), 11'(ok), 11'(1));
         if (state_out == 2'd2) saw_red = 1'b1;
         prev_st = state_out; prev_t = t;
         @(posedge clk); #1;
      end
      check("tick4_reach_red", 11'(saw_red), 11'(1));

      // ---------------- flash entered from YELLOW on expiry ----------------
      do_reset(1'b0);
      apply("fy_load",   0,1,1,0,0, pk(0,3'b001,0,1,0,0,0,0));
      apply("fy_green",  0,1,1,0,0, pk(0,3'b000,1,1,0,0,0,0));
      apply("fy_yload",  0,0,0,0,0, pk(1,3'b010,0,0,1,0,0,0));
      apply("fy_expire", 0,1,1,1,0, pk(1,3'b000,1,0,1,0,0,0));
      apply("fy_enter",  0,1,0,1,0, pk(3,3'b000,0,0,0,0,0,0));
      apply("fy_ph1",    0,0,0,1,1, pk(3,3'b000,0,0,1,0,0,0));
      apply("fy_ph1b",   0,1,0,1,0, pk(3,3'b000,0,0,1,0,0,0));
      apply("fy_ph0",    0,0,0,1,0, pk(3,3'b000,0,0,0,0,0,0));
      apply("fy_drop",   0,1,0,0,0, pk(3,3'b000,0,0,0,0,0,0));
      apply("fy_redld",  0,0,0,0,0, pk(2,3'b100,0,0,0,1,1,1));
      apply("fy_red2",   0,0,0,0,0, pk(2,3'b000,0,0,0,1,1,0));

      // ---------------- reset during RED load cycle ----------------
      do_reset(1'b0);
      apply("rr_load",   0,1,1,0,1, pk(0,3'b001,0,1,0,0,0,0));
      apply("rr_green",  0,1,1,0,0, pk(0,3'b000,1,1,0,0,0,0));
      apply("rr_yload",  0,0,0,0,0, pk(1,3'b010,0,0,1,0,0,0));
      apply("rr_yel",    0,1,1,0,0, pk(1,3'b000,1,0,1,0,0,0));
      apply("rr_redld",  1,1,1,0,0, pk(2,3'b100,0,0,0,1,1,1));
      apply("rr_after",  0,0,0,0,0, pk(0,3'b001,0,1,0,0,0,0));
      apply("rr_green2", 0,1,1,0,0, pk(0,3'b000,1,1,0,0,0,0));
      apply("rr_yload2", 0,0,0,0,0, pk(1,3'b010,0,0,1,0,0,0));
      apply("rr_yel2",   0,1,1,0,0, pk(1,3'b000,1,0,1,0,0,0));
      apply("rr_nowalk", 0,0,0,0,0, pk(2,3'b100,0,0,0,1,0,0));

      // ---------------- randomized run against the model ----------------
      do_reset(1'b0);
      fl = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) fl = !fl;
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, fl, $urandom_range(0, 15) == 0);
         @(negedge clk);
         check($sformatf("random_c%0d", k), outs(), model_exp(tick));
         model_step(rst, tick, last_drv, flash_mode, ped_req);
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
